// File: rtl/paddle_ctrl_pkg.sv
// Shared types for the paddle input controller: FSM state and step direction.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package paddle_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  typedef logic dir_t;

  localparam dir_t DIR_UP = 1'b0;
  localparam dir_t DIR_DN = 1'b1;

  // Direction of the button that is not currently active.
  function automatic dir_t flip_dir(input dir_t d);
    return ~d;
  endfunction

endpackage

// File: rtl/repeat_timer.sv
// Loadable down-counter that parks at zero; zero_o flags the parked state.
// Latency: load/clear take effect at the next clk edge; zero_o is combinational from the count.
// Backpressure: none, control inputs are obeyed every cycle.
module repeat_timer #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  input  logic                 clear,
  output logic                 zero_o
);

  localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt;

  // Clear beats load; otherwise count down and stop at zero.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign zero_o = (cnt == '0);

endmodule

// File: rtl/paddle_input_ctrl.sv
// Turns debounced UP/DOWN levels and press pulses into paddle step pulses with auto-repeat.
// Latency: a press pulse yields a step one cycle later; all outputs registered.
// Backpressure: none, steps are one-cycle requests and press pulses are consumed immediately.
module paddle_input_ctrl
  import paddle_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH     = 20,
  parameter int REPEAT_DELAY  = 500000,
  parameter int REPEAT_PERIOD = 100000
) (
  input  logic clk,
  input  logic arst_n,
  input  logic en_i,
  input  logic up_state_i,
  input  logic up_down_i,
  input  logic dn_state_i,
  input  logic dn_down_i,
  output logic step_up_o,
  output logic step_dn_o,
  output logic held_o
);

  // The timer reaches zero after N-1 decrements, so a load of N-1 gives a step N edges later.
  localparam logic [CNT_WIDTH-1:0] DELAY_LD  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LD = CNT_WIDTH'(REPEAT_PERIOD - 1);

  state_t state, nxt_state;
  dir_t   dir, nxt_dir;
  logic   fire;
  logic   nxt_up, nxt_dn, nxt_held;

  logic                 tmr_load, tmr_clear, tmr_zero;
  logic [CNT_WIDTH-1:0] tmr_val;

  logic act_lvl, oth_lvl, act_pulse, oth_pulse;

  assign act_lvl   = (dir == DIR_UP) ? up_state_i : dn_state_i;
  assign oth_lvl   = (dir == DIR_UP) ? dn_state_i : up_state_i;
  assign act_pulse = (dir == DIR_UP) ? up_down_i  : dn_down_i;
  assign oth_pulse = (dir == DIR_UP) ? dn_down_i  : up_down_i;

  repeat_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk     (clk),
    .arst_n  (arst_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .clear   (tmr_clear),
    .zero_o  (tmr_zero)
  );

  // Next-state decision: enable gate, then new press, then release, then timer expiry.
  always_comb begin
    nxt_state = state;
    nxt_dir   = dir;
    fire      = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_val   = DELAY_LD;
    if (!en_i) begin
      nxt_state = IDLE;
      tmr_clear = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          // Simultaneous presses from idle are ambiguous and dropped.
          if (up_down_i ^ dn_down_i) begin
            nxt_dir   = up_down_i ? DIR_UP : DIR_DN;
            fire      = 1'b1;
            nxt_state = HOLD;
            tmr_load  = 1'b1;
          end
        end
        HOLD, REPEAT: begin
          if (oth_pulse && !act_pulse) begin
            // Most recent press takes over with an immediate step.
            nxt_dir   = flip_dir(dir);
            fire      = 1'b1;
            nxt_state = HOLD;
            tmr_load  = 1'b1;
          end else if (!act_lvl) begin
            // Release outranks a same-cycle timer expiry and never steps.
            if (oth_lvl) begin
              nxt_dir   = flip_dir(dir);
              nxt_state = HOLD;
              tmr_load  = 1'b1;
            end else begin
              nxt_state = IDLE;
              tmr_clear = 1'b1;
            end
          end else if (tmr_zero) begin
            fire      = 1'b1;
            nxt_state = REPEAT;
            tmr_load  = 1'b1;
            tmr_val   = PERIOD_LD;
          end
        end
        default: begin
          nxt_state = IDLE;
          tmr_clear = 1'b1;
        end
      endcase
    end
    nxt_up   = fire && (nxt_dir == DIR_UP);
    nxt_dn   = fire && (nxt_dir == DIR_DN);
    nxt_held = (nxt_state != IDLE);
  end

  // State, direction and registered outputs.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state     <= IDLE;
      dir       <= DIR_UP;
      step_up_o <= 1'b0;
      step_dn_o <= 1'b0;
      held_o    <= 1'b0;
    end else begin
      state     <= nxt_state;
      dir       <= nxt_dir;
      step_up_o <= nxt_up;
      step_dn_o <= nxt_dn;
      held_o    <= nxt_held;
    end
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Scoreboard bench for paddle_input_ctrl: a timestamp-based model predicts the outputs of every cycle.
// Latency: expectations are pushed at each active edge and checked 1 time unit later.
// Backpressure: n/a.
module tb_paddle_input_ctrl;

  localparam int DLY = 5;
  localparam int PER = 3;

  logic clk = 1'b0;
  logic arst_n, en_i, up_state_i, up_down_i, dn_state_i, dn_down_i;
  logic step_up_o, step_dn_o, held_o;

  // Requested input values, applied at the next falling edge.
  logic b_rst, b_en, b_us, b_ud, b_ds, b_dd;

  typedef struct packed {
    logic su;
    logic sd;
    logic hd;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // Model: which button owns the paddle (0 none, 1 up, 2 down) and absolute cycle of its next step.
  int act   = 0;
  int t     = 0;
  int nxt_t = 0;

  paddle_input_ctrl #(
    .CNT_WIDTH    (8),
    .REPEAT_DELAY (DLY),
    .REPEAT_PERIOD(PER)
  ) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .en_i      (en_i),
    .up_state_i(up_state_i),
    .up_down_i (up_down_i),
    .dn_state_i(dn_state_i),
    .dn_down_i (dn_down_i),
    .step_up_o (step_up_o),
    .step_dn_o (step_dn_o),
    .held_o    (held_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, a, e, $time);
    end
  endtask

  function automatic logic lvl(input int b);
    return (b == 1) ? up_state_i : dn_state_i;
  endfunction

  function automatic logic pls(input int b);
    return (b == 1) ? up_down_i : dn_down_i;
  endfunction

  // Predict outputs after this edge from the sampled inputs and push them.
  task automatic model_step();
    exp_t e;
    int   oth;
    int   stepped;
    stepped = 0;
    t++;
    if (!arst_n || !en_i) begin
      act = 0;
    end else if (act == 0) begin
      if (up_down_i != dn_down_i) begin
        act     = up_down_i ? 1 : 2;
        stepped = 1;
        nxt_t   = t + DLY;
      end
    end else begin
      oth = 3 - act;
      if (pls(oth) && !pls(act)) begin
        act     = oth;
        stepped = 1;
        nxt_t   = t + DLY;
      end else if (!lvl(act)) begin
        if (lvl(oth)) begin
          act   = oth;
          nxt_t = t + DLY;
        end else begin
          act = 0;
        end
      end else if (t == nxt_t) begin
        stepped = 1;
        nxt_t   = t + PER;
      end
    end
    e.su = (stepped == 1) && (act == 1);
    e.sd = (stepped == 1) && (act == 2);
    e.hd = (act != 0);
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    logic rst_was;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_was    = arst_n;
      arst_n     = b_rst;
      en_i       = b_en;
      up_state_i = b_us;
      up_down_i  = b_ud;
      dn_state_i = b_ds;
      dn_down_i  = b_dd;
      if (rst_was && !b_rst) begin
        #1;
        check("async_rst step_up", step_up_o, 1'b0);
        check("async_rst step_dn", step_dn_o, 1'b0);
        check("async_rst held", held_o, 1'b0);
      end
      @(posedge clk);
      model_step();
      b_ud = 1'b0;
      b_dd = 1'b0;
    end
  endtask

  // Monitor: compare every registered output cycle against the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if ({step_up_o, step_dn_o, held_o} !== e) begin
        bad++;
        $display("FAIL outputs cycle %0d: got up=%b dn=%b held=%b want up=%b dn=%b held=%b",
                 t, step_up_o, step_dn_o, held_o, e.su, e.sd, e.hd);
      end
    end
  end

  initial begin
    arst_n = 1'b0; en_i = 1'b0;
    up_state_i = 1'b0; up_down_i = 1'b0; dn_state_i = 1'b0; dn_down_i = 1'b0;
    b_rst = 1'b0; b_en = 1'b0; b_us = 1'b0; b_ud = 1'b0; b_ds = 1'b0; b_dd = 1'b0;
    #2;
    check("reset step_up", step_up_o, 1'b0);
    check("reset step_dn", step_dn_o, 1'b0);
    check("reset held", held_o, 1'b0);
    tick(2);
    b_rst = 1'b1; b_en = 1'b1;
    tick(2);

    // UP pressed and held for 20 cycles.
    b_us = 1'b1; b_ud = 1'b1; tick(1);
    tick(20);
    b_us = 1'b0; tick(3);

    // Both presses in the same cycle from idle.
    b_us = 1'b1; b_ds = 1'b1; b_ud = 1'b1; b_dd = 1'b1; tick(1);
    tick(4);
    b_us = 1'b0; b_ds = 1'b0; tick(2);

    // Hold UP, DOWN press at E3, release DOWN while UP still held.
    b_us = 1'b1; b_ud = 1'b1; tick(1);
    tick(2);
    b_ds = 1'b1; b_dd = 1'b1; tick(1);
    tick(7);
    b_ds = 1'b0; tick(8);
    b_us = 1'b0; tick(3);

    // Enable drop while UP held, then a fresh press.
    b_us = 1'b1; b_ud = 1'b1; tick(1);
    tick(6);
    b_en = 1'b0; tick(1);
    b_en = 1'b1; tick(8);
    b_ud = 1'b1; tick(1);
    tick(6);
    b_us = 1'b0; tick(2);

    // Release on the edge where the delay expires.
    b_us = 1'b1; b_ud = 1'b1; tick(1);
    tick(4);
    b_us = 1'b0; tick(3);

    // Asynchronous reset while a repeat step is on the outputs.
    b_us = 1'b1; b_ud = 1'b1; tick(1);
    tick(8);
    b_rst = 1'b0; tick(2);
    b_rst = 1'b1; tick(5);
    b_us = 1'b0; tick(2);

    // Randomised button activity.
    for (int i = 0; i < 3000; i++) begin
      if (!b_us && !b_ds && $urandom_range(40) == 0) begin
        b_us = 1'b1; b_ud = 1'b1; b_ds = 1'b1; b_dd = 1'b1;
      end else begin
        if (!b_us && $urandom_range(5) == 0) begin
          b_us = 1'b1; b_ud = 1'b1;
        end else if (b_us && $urandom_range(11) == 0) begin
          b_us = 1'b0;
        end
        if (!b_ds && $urandom_range(5) == 0) begin
          b_ds = 1'b1; b_dd = 1'b1;
        end else if (b_ds && $urandom_range(11) == 0) begin
          b_ds = 1'b0;
        end
      end
      b_en  = ($urandom_range(49) != 0);
      b_rst = ($urandom_range(499) != 0);
      tick(1);
    end
    b_rst = 1'b1; b_en = 1'b1; b_us = 1'b0; b_ds = 1'b0;
    tick(3);
    #5;
    check("scoreboard drained", exp_q.size() == 0, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paddle_input_ctrl.md
# paddle_input_ctrl

Turns the debounced outputs of two button debouncers (UP and DOWN) for one player into paddle step commands. It emits one step on each press and auto-repeats while the button is held, after an initial delay. Simultaneous presses are arbitrated, and the most recent press wins. One instance per player sits between the debouncers and the game-logic paddle position register.

## Interface
- CNT_WIDTH, 20: width of the repeat timer.
- REPEAT_DELAY, 500000: cycles from the initial step to the first auto-repeat step. Must be ≥2 and fit in CNT_WIDTH.
- REPEAT_PERIOD, 100000: cycles between subsequent auto-repeat steps. Must be ≥2 and fit in CNT_WIDTH.
- clk  in  1  system clock.
- arst_n  in  1  reset, asynchronous, active-low.
- en_i  in  1  game running; low suppresses all steps.
- up_state_i  in  1  debounced UP level, 1 = pressed.
- up_down_i  in  1  UP press pulse, one cycle.
- dn_state_i  in  1  debounced DOWN level, 1 = pressed.
- dn_down_i  in  1  DOWN press pulse, one cycle.
- step_up_o  out  1  one-cycle request to move the paddle up.
- step_dn_o  out  1  one-cycle request to move the paddle down.
- held_o  out  1  high while in HOLD or REPEAT.

## Operation
- Reset: FSM = IDLE, dir = UP, timer = 0. step_up_o, step_dn_o and held_o are all 0.
- States:
  - IDLE: no button active.
  - HOLD: waiting out REPEAT_DELAY.
  - REPEAT: stepping every REPEAT_PERIOD.
- IDLE, exactly one press pulse: set dir to that button, emit a step in dir, load timer with REPEAT_DELAY-1, go to HOLD.
- IDLE, both press pulses in the same cycle: no step, stay in IDLE.
- HOLD/REPEAT, press pulse of the non-active button only: dir flips, emit a step in the new dir, load REPEAT_DELAY-1, go to HOLD. Last press wins.
- HOLD/REPEAT, both pulses together: ignored, current behaviour continues.
- Active button level drops:
  - If the other button's level is high: dir flips, load REPEAT_DELAY-1, go to HOLD, no immediate step.
  - Otherwise: go to IDLE and clear the timer.
- Release has priority over timer expiry in the same cycle. No step is emitted.
- HOLD, timer == 0 with active level high: emit a step, load REPEAT_PERIOD-1, go to REPEAT.
- REPEAT, timer == 0: emit a step, reload REPEAT_PERIOD-1.
- Otherwise the timer decrements by 1, saturating at 0.
- en_i low: next state IDLE, timer cleared, no steps emitted, and press pulses in that cycle are discarded. The block resumes only on a fresh press pulse after en_i returns high.
- step_up_o and step_dn_o are never high in the same cycle.

## Timing
- All outputs are registered.
- A press pulse sampled at edge E0 produces a step output in the cycle after E0 (latency 1).
- With the button held, later step outputs appear after edges E0+REPEAT_DELAY, then E0+REPEAT_DELAY+k·REPEAT_PERIOD.
- Each step output is exactly 1 cycle wide.
- held_o follows the registered state: it rises in the same cycle as the first step output.
- Asynchronous reset mid-operation forces all outputs low immediately. The FSM restarts in IDLE.

## Structure
- Package paddle_ctrl_pkg holds:
  - the state enum (IDLE, HOLD, REPEAT) as a 2-bit typedef;
  - the dir typedef, with constants DIR_UP = 1'b0 and DIR_DN = 1'b1.
- Sub-module repeat_timer: loadable CNT_WIDTH down-counter, saturating at 0.
  - Inputs: load, load_val, clear.
  - Output: zero_o.
- The FSM and output registers live in paddle_input_ctrl.

## Test plan
- Reset. Defaults are REPEAT_DELAY=5, REPEAT_PERIOD=3; the scenarios below use these unless stated.
- UP pulse at E0, level held 20 cycles -> step_up_o after E0, E0+5, E0+8, E0+11, …; no step_dn_o.
- UP and DOWN pulses in the same cycle from IDLE -> no steps, held_o stays 0.
- Hold UP, then DOWN pulse at E3 -> step_dn_o after E3. Next step_dn_o after E3+5. Then release DOWN with UP still high -> no immediate step, step_up_o 5 cycles later.
- Hold UP, then drop en_i for 1 cycle -> no further steps even though UP is still high. A fresh UP pulse restarts stepping with latency 1.
- Release UP on the exact cycle the timer reaches 0 -> no step, FSM returns to IDLE.
- Assert arst_n low mid-REPEAT -> all outputs 0 immediately. After release, nothing until a new pulse.
